// File: rtl/uart_rx_deframer_if.sv
// Serial-in / word-out bundle of the UART receive framer.
// Handshake: o_valid and o_frame_err are single-cycle strobes with no ready.
// The consumer must take o_data in the o_valid cycle. o_data also stays valid until the next good frame.
interface uart_rx_deframer_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_sig;
  logic                 i_is_fe;
  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 o_frame_err;
  logic                 o_busy;
  logic [1:0]           o_state;

  modport master (
    output i_sig, i_is_fe,
    input  o_data, o_valid, o_frame_err, o_busy, o_state
  );

  modport slave (
    input  i_sig, i_is_fe,
    output o_data, o_valid, o_frame_err, o_busy, o_state
  );
endinterface

// File: rtl/uart_rx_deframer.sv
// UART receive framer: start-bit check at mid-bit, LSB-first data sampling at bit
// centres, stop-bit check, then a one-cycle valid or framing-error strobe.
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic              i_Clk,
  input  logic              i_reset,
  uart_rx_deframer_if.slave bus
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  always_ff @(posedge i_Clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (bus.i_is_fe) state_d = START;
      end
      START: begin
        // A line that is high again at mid-start was a glitch, not a start bit.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = bus.i_sig ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {bus.i_sig, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = STOP;
          end
        end
      end
      STOP: begin
        // Leaving at mid-stop-bit gives half a bit of slack for the next start edge.
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (bus.i_sig) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end else begin
            ferr_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_data      = data_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_frame_err = ferr_q;
  assign bus.o_busy      = (state_q != IDLE);
  assign bus.o_state     = state_q;
endmodule
